// File: rtl/harmonic_voice.sv
// Additive-synthesis voice: NUM_HARM phase accumulators share one external sine ROM;
// per-harmonic gains shape the mix, and a beat-driven duration counter gates the note.
module harmonic_voice #(
  parameter int NUM_HARM = 7,
  parameter int SAMPLE_W = 16,
  parameter int STEP_W   = 20,
  parameter int ROM_AW   = 10,
  parameter int DUR_W    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic                       load_new_note,
  input  logic [STEP_W-1:0]          step_in,
  input  logic [DUR_W-1:0]           duration_in,
  input  logic                       beat,
  output logic                       done_with_note,
  input  logic                       generate_next_sample,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready,
  input  logic                       gain_we,
  input  logic [2:0]                 gain_addr,
  input  logic [3:0]                 gain_data,
  output logic [ROM_AW-1:0]          rom_addr,
  input  logic signed [SAMPLE_W-1:0] rom_data
);

  localparam int ACC_W = SAMPLE_W + 3;
  localparam logic [2:0] LAST = 3'(NUM_HARM - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

  state_t                  state;
  logic [2:0]              idx;
  logic [STEP_W-1:0]       phase [NUM_HARM];
  logic [3:0]              gain  [NUM_HARM];
  logic [STEP_W-1:0]       step;
  logic [DUR_W-1:0]        count;
  logic                    pending;
  logic [STEP_W-1:0]       pend_step;
  logic [DUR_W-1:0]        pend_dur;
  logic signed [ACC_W-1:0] acc;

  logic                    active;
  logic                    issue;
  logic                    load_fire;
  logic [2:0]              iss_idx;
  logic [2:0]              acc_idx;
  logic [ROM_AW-1:0]       iss_addr;
  logic [STEP_W-1:0]       inc;
  logic [STEP_W-1:0]       ld_step;
  logic [DUR_W-1:0]        ld_dur;
  logic [3:0]              acc_gain;
  logic signed [ACC_W-1:0] contrib;

  function automatic logic signed [ACC_W-1:0] shape(input logic signed [SAMPLE_W-1:0] w,
                                                     input logic [3:0] g);
    logic signed [ACC_W-1:0] ext;
    ext = {{3{w[SAMPLE_W-1]}}, w};
    if (g == 4'hF) return '0;
    return ext >>> g;
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic [3:0] top;
    top = a[ACC_W-1 -: 4];
    if (top == 4'b0000 || top == 4'b1111) return a[SAMPLE_W-1:0];
    if (a[ACC_W-1]) return {1'b1, {(SAMPLE_W-1){1'b0}}};
    return {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  assign done_with_note = (count == '0);

  // idx names the harmonic whose address is on rom_addr; its ROM word lands one cycle later
  always_comb begin
    active    = play_enable && !done_with_note;
    issue     = ((state == IDLE) && generate_next_sample) || ((state == FETCH) && (idx != LAST));
    iss_idx   = (state == IDLE) ? 3'd0 : idx + 3'd1;
    acc_idx   = (state == DRAIN) ? LAST : idx - 3'd1;
    load_fire = ((state == IDLE) && load_new_note) ||
                ((state == OUT) && (load_new_note || pending));
    ld_step   = load_new_note ? step_in : pend_step;
    ld_dur    = load_new_note ? duration_in : pend_dur;
    iss_addr  = '0;
    acc_gain  = 4'hF;
    for (int k = 0; k < NUM_HARM; k++) begin
      if (iss_idx == 3'(k)) iss_addr = phase[k][STEP_W-1 -: ROM_AW];
      if (acc_idx == 3'(k)) acc_gain = gain[k];
    end
    inc     = step * STEP_W'(32'(iss_idx) + 32'd1);
    contrib = active ? shape(rom_data, acc_gain) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      idx              <= '0;
      rom_addr         <= '0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
      step             <= '0;
      count            <= '0;
      pending          <= 1'b0;
      for (int k = 0; k < NUM_HARM; k++) begin
        phase[k] <= '0;
        gain[k]  <= (k == 0) ? 4'h1 : 4'hF;
      end
    end else begin
      new_sample_ready <= 1'b0;
      if (issue) rom_addr <= iss_addr;
      for (int k = 0; k < NUM_HARM; k++) begin
        if (load_fire) phase[k] <= '0;
        else if (issue && active && (iss_idx == 3'(k))) phase[k] <= phase[k] + inc;
        if (gain_we && (gain_addr == 3'(k))) gain[k] <= gain_data;
      end
      // an applied load wins over a coincident beat
      if (load_fire) begin
        step  <= ld_step;
        count <= ld_dur;
      end else if (beat && play_enable && !done_with_note) begin
        count <= count - 1'b1;
      end
      if (load_fire) pending <= 1'b0;
      else if (load_new_note) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (generate_next_sample) begin
            state <= FETCH;
            idx   <= '0;
          end
        end
        FETCH: begin
          if (idx == LAST) state <= DRAIN;
          else idx <= idx + 3'd1;
        end
        DRAIN: state <= OUT;
        OUT: begin
          sample_out       <= saturate(acc);
          new_sample_ready <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // accumulator stage: one harmonic per cycle, trailing the address stream by one
  always_ff @(posedge clk) begin
    if (load_new_note) begin
      pend_step <= step_in;
      pend_dur  <= duration_in;
    end
    case (state)
      IDLE:    if (generate_next_sample) acc <= '0;
      FETCH:   if (idx != 3'd0) acc <= acc + contrib;
      DRAIN:   acc <= acc + contrib;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_harmonic_voice.sv
// Directed bench for harmonic_voice: registered ROM model, hand-computed sample values.
module tb_harmonic_voice;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               play_enable = 1'b0;
  logic               load_new_note = 1'b0;
  logic [19:0]        step_in = '0;
  logic [5:0]         duration_in = '0;
  logic               beat = 1'b0;
  logic               done_with_note;
  logic               generate_next_sample = 1'b0;
  logic signed [15:0] sample_out;
  logic               new_sample_ready;
  logic               gain_we = 1'b0;
  logic [2:0]         gain_addr = '0;
  logic [3:0]         gain_data = '0;
  logic [9:0]         rom_addr;
  logic signed [15:0] rom_data;

  logic               rom_mode = 1'b0;
  logic signed [15:0] rom_force = '0;
  int                 total = 0;
  int                 bad = 0;

  always #5 clk = ~clk;

  // table mode: ROM[a] = 1000 + 32*a
  always @(posedge clk) rom_data <= rom_mode ? rom_force : 16'(1000 + 32 * int'(rom_addr));

  harmonic_voice dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .load_new_note(load_new_note),
    .step_in(step_in), .duration_in(duration_in), .beat(beat), .done_with_note(done_with_note),
    .generate_next_sample(generate_next_sample), .sample_out(sample_out),
    .new_sample_ready(new_sample_ready), .gain_we(gain_we), .gain_addr(gain_addr),
    .gain_data(gain_data), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_gain(input int a, input logic [3:0] d);
    gain_we = 1'b1; gain_addr = 3'(a); gain_data = d;
    tick();
    gain_we = 1'b0;
  endtask

  task automatic load_note(input logic [19:0] s, input logic [5:0] d);
    step_in = s; duration_in = d; load_new_note = 1'b1;
    tick();
    load_new_note = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic run_sample(output logic signed [15:0] s, output int lat, output logic [9:0] a0);
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    a0  = rom_addr;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (new_sample_ready) begin
        lat = i;
        break;
      end
    end
    s = sample_out;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++; if (sample_out !== 16'h0000) begin bad++; $display("FAIL rst_sample: got %h want 0000", sample_out); end
    total++; if (new_sample_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", new_sample_ready); end
    total++; if (rom_addr !== 10'h000) begin bad++; $display("FAIL rst_rom_addr: got %h want 000", rom_addr); end
    total++; if (done_with_note !== 1'b1) begin bad++; $display("FAIL rst_done: got %b want 1", done_with_note); end
    reset = 1'b1;
    tick();
    total++; if (done_with_note !== 1'b1) begin bad++; $display("FAIL rst_done_after: got %b want 1", done_with_note); end
  endtask

  task automatic test_basic();
    logic signed [15:0] s; int lat; logic [9:0] a0;
    play_enable = 1'b1;
    load_note(20'h00400, 6'd3);
    total++; if (done_with_note !== 1'b0) begin bad++; $display("FAIL basic_done: got %b want 0", done_with_note); end
    run_sample(s, lat, a0);
    total++; if (lat != 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
    total++; if (a0 !== 10'd0) begin bad++; $display("FAIL basic_addr0: got %0d want 0", a0); end
    total++; if (s !== 16'sd500) begin bad++; $display("FAIL basic_sample: got %0d want 500", s); end
    tick();
    total++; if (new_sample_ready !== 1'b0) begin bad++; $display("FAIL basic_pulse_width: got %b want 0", new_sample_ready); end
    total++; if (sample_out !== 16'sd500) begin bad++; $display("FAIL basic_hold: got %0d want 500", sample_out); end
    run_sample(s, lat, a0);
    total++; if (a0 !== 10'd1) begin bad++; $display("FAIL basic_phase1: got %0d want 1", a0); end
    total++; if (s !== 16'sd516) begin bad++; $display("FAIL basic_sample2: got %0d want 516", s); end
  endtask

  task automatic test_gain_sat();
    logic signed [15:0] s; int lat; logic [9:0] a0;
    for (int i = 0; i < 7; i++) write_gain(i, 4'h0);
    rom_mode = 1'b1;
    rom_force = 16'h7FFF;
    run_sample(s, lat, a0);
    total++; if (s !== 16'h7FFF) begin bad++; $display("FAIL sat_pos: got %h want 7fff", s); end
    rom_force = 16'h8000;
    run_sample(s, lat, a0);
    total++; if (s !== 16'h8000) begin bad++; $display("FAIL sat_neg: got %h want 8000", s); end
    write_gain(1, 4'h1); write_gain(2, 4'h2);
    for (int i = 3; i < 7; i++) write_gain(i, 4'hF);
    rom_force = 16'h1000;
    run_sample(s, lat, a0);
    total++; if (s !== 16'h1C00) begin bad++; $display("FAIL gain_mix: got %h want 1c00", s); end
    write_gain(0, 4'h3); write_gain(1, 4'hF); write_gain(2, 4'hF);
    rom_force = 16'hF000;
    run_sample(s, lat, a0);
    total++; if (s !== 16'hFE00) begin bad++; $display("FAIL gain_arith_shift: got %h want fe00", s); end
  endtask

  task automatic test_duration();
    logic signed [15:0] s; int lat; logic [9:0] a0;
    write_gain(0, 4'h0);
    rom_mode = 1'b0;
    load_note(20'h00400, 6'd2);
    play_enable = 1'b0;
    pulse_beat();
    total++; if (done_with_note !== 1'b0) begin bad++; $display("FAIL dur_paused_beat: got %b want 0", done_with_note); end
    play_enable = 1'b1;
    pulse_beat();
    total++; if (done_with_note !== 1'b0) begin bad++; $display("FAIL dur_beat1: got %b want 0", done_with_note); end
    pulse_beat();
    total++; if (done_with_note !== 1'b1) begin bad++; $display("FAIL dur_beat2: got %b want 1", done_with_note); end
    run_sample(s, lat, a0);
    total++; if (s !== 16'sd0) begin bad++; $display("FAIL dur_silent: got %0d want 0", s); end
    run_sample(s, lat, a0);
    total++; if (a0 !== 10'd0) begin bad++; $display("FAIL dur_phase_hold: got %0d want 0", a0); end
    total++; if (s !== 16'sd0) begin bad++; $display("FAIL dur_silent2: got %0d want 0", s); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0; int last = -1; int extra = 0;
    load_note(20'h00400, 6'd5);
    generate_next_sample = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (new_sample_ready) begin
        pulses++;
        if (last < 0) begin
          total++; if (i != 9) begin bad++; $display("FAIL b2b_first: got %0d want 9", i); end
        end else begin
          total++; if (i - last != 10) begin bad++; $display("FAIL b2b_gap: got %0d want 10", i - last); end
        end
        last = i;
      end
    end
    generate_next_sample = 1'b0;
    total++; if (pulses != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", pulses); end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (new_sample_ready) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL b2b_extra: got %0d want 0", extra); end
  endtask

  task automatic test_load_in_fetch();
    logic signed [15:0] s; int lat; logic [9:0] a0;
    rom_mode = 1'b0;
    load_note(20'h00400, 6'd20);
    run_sample(s, lat, a0);
    total++; if (s !== 16'sd1000) begin bad++; $display("FAIL lif_pre: got %0d want 1000", s); end
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    total++; if (rom_addr !== 10'd1) begin bad++; $display("FAIL lif_addr: got %0d want 1", rom_addr); end
    tick();
    step_in = 20'h00800; duration_in = 6'd20; load_new_note = 1'b1;
    tick();
    load_new_note = 1'b0;
    lat = -1;
    for (int i = 3; i <= 20; i++) begin
      tick();
      if (new_sample_ready) begin
        lat = i;
        break;
      end
    end
    total++; if (lat != 9) begin bad++; $display("FAIL lif_latency: got %0d want 9", lat); end
    total++; if (sample_out !== 16'sd1032) begin bad++; $display("FAIL lif_old_step: got %0d want 1032", sample_out); end
    run_sample(s, lat, a0);
    total++; if (a0 !== 10'd0) begin bad++; $display("FAIL lif_cleared: got %0d want 0", a0); end
    total++; if (s !== 16'sd1000) begin bad++; $display("FAIL lif_sample3: got %0d want 1000", s); end
    run_sample(s, lat, a0);
    total++; if (a0 !== 10'd2) begin bad++; $display("FAIL lif_new_step: got %0d want 2", a0); end
    total++; if (s !== 16'sd1064) begin bad++; $display("FAIL lif_sample4: got %0d want 1064", s); end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] s; int lat; logic [9:0] a0; int seen = 0;
    write_gain(1, 4'h0);
    rom_mode = 1'b1;
    rom_force = 16'h0400;
    load_note(20'h00000, 6'd5);
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++; if (done_with_note !== 1'b1) begin bad++; $display("FAIL rmid_done: got %b want 1", done_with_note); end
    total++; if (rom_addr !== 10'd0) begin bad++; $display("FAIL rmid_addr: got %0d want 0", rom_addr); end
    total++; if (sample_out !== 16'sd0) begin bad++; $display("FAIL rmid_sample: got %0d want 0", sample_out); end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (new_sample_ready) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rmid_no_ready: got %0d want 0", seen); end
    load_note(20'h00000, 6'd5);
    run_sample(s, lat, a0);
    total++; if (lat != 9) begin bad++; $display("FAIL rmid_fresh_latency: got %0d want 9", lat); end
    total++; if (s !== 16'h0200) begin bad++; $display("FAIL rmid_gain_restored: got %h want 0200", s); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gain_sat();
    test_duration();
    test_back_to_back();
    test_load_in_fetch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
